// File: rtl/nios_system_data_out_pkg.sv
// Register map and bit positions for the nios_system_data_out write port.
// Optional irq output is enabled by defining NIOS_SYSTEM_DATA_OUT_IRQ_EN.
package nios_system_data_out_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_CLEAR   = 2'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 3;
  localparam int ST_IRQ     = 8;

  localparam int CTL_EN       = 0;
  localparam int CTL_IRQ_MASK = 1;

  localparam int CLR_OVF   = 0;
  localparam int CLR_FLUSH = 1;

  // bit order matches the CONTROL register layout
  typedef struct packed {
    logic irq_mask;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/nios_system_data_out_fifo.sv
// Small register-based FIFO: registered storage, combinational head read,
// simultaneous push/pop when full, synchronous flush.
module nios_system_data_out_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // pointers are power-of-two wide, so natural overflow wraps them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/nios_system_data_out.sv
// Avalon-MM outbound port: Nios writes words into a FIFO drained by a valid/ready
// consumer. Define NIOS_SYSTEM_DATA_OUT_IRQ_EN to add the irq output.
module nios_system_data_out
  import nios_system_data_out_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic [DW-1:0] out_port,
  output logic          out_valid,
  input  logic          out_ready
`ifdef NIOS_SYSTEM_DATA_OUT_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ctrl_t          ctrl;
  logic           overflow;
  logic [DW-1:0]  last_wr;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           irq_r;
  logic [31:0]    rd_next;

  logic wr, wr_data, wr_ctrl, wr_clear;
  logic push, pop, flush, ovf_set, ovf_clr;

  assign wr       = chipselect & ~write_n;
  assign wr_data  = wr & (address == ADDR_DATA);
  assign wr_ctrl  = wr & (address == ADDR_CONTROL);
  assign wr_clear = wr & (address == ADDR_CLEAR);

  assign flush   = wr_clear & writedata[CLR_FLUSH];
  assign ovf_clr = wr_clear & writedata[CLR_OVF];

  assign out_valid = ctrl.enable & ~empty;
  assign pop       = out_valid & out_ready;
  // a full FIFO still accepts a word when the head leaves in the same cycle
  assign push      = wr_data & (~full | pop) & ~flush;
  assign ovf_set   = wr_data & full & ~pop & ~flush;

  nios_system_data_out_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (writedata[DW-1:0]),
    .head    (out_port),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      overflow <= 1'b0;
      last_wr  <= '0;
    end else begin
      if (wr_ctrl)
        ctrl <= ctrl_t'(writedata[1:0]);
      overflow <= (overflow & ~ovf_clr) | ovf_set;
      if (push)
        last_wr <= writedata[DW-1:0];
    end
  end

`ifdef NIOS_SYSTEM_DATA_OUT_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_r <= 1'b0;
    else          irq_r <= ctrl.irq_mask & (empty | overflow);
  end
  assign irq = irq_r;
`else
  assign irq_r = 1'b0;
`endif

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[DW-1:0] = last_wr;
      ADDR_STATUS: begin
        rd_next[ST_FULL]             = full;
        rd_next[ST_EMPTY]            = empty;
        rd_next[ST_OVF]              = overflow;
        rd_next[ST_CNT_LSB +: CW]    = count;
        rd_next[ST_IRQ]              = irq_r;
      end
      ADDR_CONTROL: begin
        rd_next[CTL_EN]       = ctrl.enable;
        rd_next[CTL_IRQ_MASK] = ctrl.irq_mask;
      end
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

endmodule

// File: tb/tb_nios_system_data_out.sv
// Bench for nios_system_data_out: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the register/FIFO behaviour.
module tb_nios_system_data_out;

  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;
  logic          out_valid;
  logic          out_ready = 1'b0;
`ifdef NIOS_SYSTEM_DATA_OUT_IRQ_EN
  logic          irq;
`endif

  nios_system_data_out #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef NIOS_SYSTEM_DATA_OUT_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] seen[$];
  logic [DW-1:0] m_last;
  bit m_en, m_mask, m_ovf, m_irq;
  int passed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_last = '0; m_en = 0; m_mask = 0; m_ovf = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = '0;
    case (address)
      2'd0: r = 32'(m_last);
      2'd1: r = 32'(q.size() == DEPTH) | (32'(q.size() == 0) << 1) | (32'(m_ovf) << 2)
              | (32'(q.size()) << 3) | (32'(m_irq) << 8);
      2'd2: r = {30'd0, m_mask, m_en};
      default: r = '0;
    endcase
    return r;
  endfunction

  // one clock: predict from pre-edge state, advance model, then compare
  task automatic tick();
    logic [31:0] erd;
    bit eirq, full_pre, do_pop, wr, ev;
    erd      = exp_rd();
    eirq     = m_mask && (q.size() == 0 || m_ovf);
    full_pre = (q.size() == DEPTH);
    do_pop   = m_en && q.size() != 0 && out_ready;
    wr       = chipselect && !write_n;
    if (out_valid && out_ready) seen.push_back(out_port);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (wr) begin
      case (address)
        2'd0: if (!full_pre || do_pop) begin
                q.push_back(writedata[DW-1:0]);
                m_last = writedata[DW-1:0];
              end else m_ovf = 1;
        2'd2: begin m_en = writedata[0]; m_mask = writedata[1]; end
        2'd3: begin
                if (writedata[0]) m_ovf = 0;
                if (writedata[1]) q.delete();
              end
        default: ;
      endcase
    end
`ifdef NIOS_SYSTEM_DATA_OUT_IRQ_EN
    m_irq = eirq;
`endif
    #1;
    ev = m_en && q.size() != 0;
    chk("readdata", readdata, erd);
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) chk("out_port", 32'(out_port), 32'(q[0]));
`ifdef NIOS_SYSTEM_DATA_OUT_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    tick();
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_port", 32'(out_port), 32'h0);
    reset_n = 1;

    // reads of all registers after reset
    for (int a = 0; a < 4; a++) rd(2'(a));
    rd(2'd0);
    chk("reset_clear_read", readdata, 32'h0);

    // single word passes straight through
    out_ready = 1;
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h1234);
    chk("single_port", 32'(out_port), 32'h1234);
    chk("single_valid", 32'(out_valid), 32'h1);
    rd(2'd1);
    chk("single_gone", 32'(out_valid), 32'h0);
    rd(2'd1);
    chk("single_status", readdata, 32'h02);

    // overflow with port disabled
    wr(2'd2, 32'h0);
    for (int i = 0; i < 5; i++) wr(2'd0, 32'hA + 32'(i));
    rd(2'd1); rd(2'd1);
    chk("ovf_status", readdata, 32'h25);
    seen.delete();
    wr(2'd2, 32'h1);
    repeat (6) rd(2'd0);
    chk("drain_len", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      chk("drain_word", 32'(seen[i]), 32'hA + 32'(i));

    // full FIFO with a same-cycle pop accepts the new word
    wr(2'd3, 32'h3);
    out_ready = 0;
    wr(2'd2, 32'h0);
    for (int i = 1; i <= 4; i++) wr(2'd0, 32'(i));
    out_ready = 1;
    seen.delete();
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h55);
    out_ready = 0;
    rd(2'd1);
    chk("pushpop_status", readdata, 32'h21);
    out_ready = 1;
    repeat (6) rd(2'd0);
    chk("pushpop_len", 32'(seen.size()), 32'd5);
    if (seen.size() == 5) begin
      chk("pushpop_w1", 32'(seen[1]), 32'h2);
      chk("pushpop_w4", 32'(seen[4]), 32'h55);
    end

    // clear + flush while two words remain and overflow is set
    out_ready = 0;
    wr(2'd2, 32'h0);
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h70 + 32'(i));
    out_ready = 1;
    wr(2'd2, 32'h1);
    rd(2'd0); rd(2'd0);
    out_ready = 0;
    rd(2'd1);
    chk("pre_clear_status", readdata, 32'h14);
    wr(2'd3, 32'h3);
    rd(2'd1);
    chk("clear_status", readdata, 32'h02);
    chk("clear_valid", 32'(out_valid), 32'h0);

`ifdef NIOS_SYSTEM_DATA_OUT_IRQ_EN
    wr(2'd2, 32'h3);
    rd(2'd0);
    chk("irq_set", 32'(irq), 32'h1);
    wr(2'd0, 32'h9);
    rd(2'd0);
    chk("irq_clr", 32'(irq), 32'h0);
`endif

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 15);
      out_ready  = ($urandom_range(0, 3) != 0);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 1) == 0);
      writedata  = $urandom();
      if (r < 8)       address = 2'd0;
      else if (r < 12) address = 2'd1;
      else if (r < 15) begin address = 2'd2; writedata[0] = ($urandom_range(0, 3) != 0); end
      else             address = 2'd3;
      tick();
    end
    chipselect = 0; write_n = 1;

    // asynchronous reset while words are queued
    out_ready = 0;
    wr(2'd3, 32'h3);
    wr(2'd2, 32'h1);
    wr(2'd0, 32'hBEEF);
    wr(2'd0, 32'hCAFE);
    chk("pre_reset_valid", 32'(out_valid), 32'h1);
    reset_n = 0;
    #1;
    model_reset();
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_port", 32'(out_port), 32'h0);
    chk("async_readdata", readdata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1;
    rd(2'd1); rd(2'd1);
    chk("post_reset_status", readdata, 32'h02);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
